panda_pcomp: RTL
================

// Module: panda_pcomp
// PURPOSE
//  Position-compare pulse generator; sits directly downstream of the counter block.
//  posn_i is the counter's 32-bit out_o.
//  Emits NUM pulses of WIDTH position units, spaced STEP apart, starting at START.
//  Pulses are placed in positive (DIR=0) or negative (DIR=1) travel.
//  Flags err_o when position jumps over a whole pulse or the config is illegal.
// PARAMETERS
//  PW  32  position/register width (bits)
// PORTS
//  clk_i      in   1   system clock
//  reset_n_i  in   1   reset, asynchronous, active-low
//  enable_i   in   1   arm (rising edge) / abort (low)
//  posn_i     in   PW  position input, two's complement (counter out_o)
//  START      in   PW  first pulse rise position
//  STEP       in   PW  pulse pitch, unsigned, must be >0
//  WIDTH      in   PW  pulse width, unsigned, 0 < WIDTH < STEP
//  NUM        in   PW  pulse count; 0 = unlimited
//  DIR        in   1   0 = positive travel, 1 = negative travel
//  act_o      out  1   armed/active
//  pulse_o    out  1   compare pulse
//  err_o      out  1   sticky error
// BEHAVIOUR
//  Reset: act_o=0, pulse_o=0, err_o=0, state=IDLE, k=0; takes effect asynchronously.
//  Shadowing: START/STEP/WIDTH/NUM/DIR are copied on the enable_i rising edge.
//   - Changes while active are ignored until the next arm.
//  Points (all mod 2^PW):
//   - Rise point R = START +/- k*STEP; fall point F = R +/- WIDTH (+ for DIR=0, - for DIR=1).
//   - R is held incrementally: R += STEP or R -= STEP; no multiplier.
//  crossed(X): wrap-safe; no magnitude compare.
//   - DIR=0: $signed(posn_i - X) >= 0.
//   - DIR=1: $signed(posn_i - X) <= 0.
//  All outputs are registered; response is 1 clk after the posn_i sample.
//  FSM states IDLE, WAIT_RISE, WAIT_FALL:
//   IDLE: act_o=0, pulse_o=0.
//    - enable_i rise with STEP==0 | WIDTH==0 | WIDTH>=STEP: err_o=1, stay IDLE.
//    - enable_i rise otherwise: err_o=0, k=0, act_o=1 -> WAIT_RISE.
//   WAIT_RISE:
//    - crossed(F): err_o=1, act_o=0 -> IDLE (jumped whole pulse).
//    - else crossed(R): pulse_o=1 -> WAIT_FALL.
//    - If posn is already past START at arm, the first pulse fires immediately.
//   WAIT_FALL:
//    - crossed(F): pulse_o=0, k++, R advances by STEP.
//    - If NUM!=0 and k==NUM: act_o=0 -> IDLE; else -> WAIT_RISE.
//    - Fall and next rise never share a cycle; the earliest next rise is the following cycle.
//  enable_i low in any state: next cycle IDLE, act_o=0, pulse_o=0; err_o keeps its value.
//  enable_i rise on the same cycle as a compare hit: arming wins; old context discarded.
//  k counter is PW bits; with NUM=0 it wraps silently.
//  Reset mid-pulse: pulse_o drops immediately; no re-arm without a new enable_i rise.
// STRUCTURE
//  pcomp_pkg:
//   - typedef enum {IDLE, WAIT_RISE, WAIT_FALL} pcomp_state_t.
//   - localparam DIR_POS=1'b0, DIR_NEG=1'b1.
//  Sub-module pcomp_cross: combinational crossed() for one threshold plus DIR.
//   - Instantiated twice, for R and F.
//  Top level holds the shadow registers, R/k registers, FSM and output flops.
// TESTING
//  Common: posn_i ramps +1/clk unless stated; wait-state cases check err_o=0, pulse_o=0.
//  1. START=100, STEP=50, WIDTH=10, NUM=3, DIR=0, posn_i 0->300:
//     - pulse_o high for posn 100-109, 150-159, 200-209 (1 clk late).
//     - act_o falls 1 clk after posn=210.
//  2. DIR=1, START=0, STEP=20, WIDTH=5, NUM=2, posn_i 10->-60 by -1/clk:
//     - pulses for posn 0..-4 and -20..-24, then act_o=0.
//  3. Jump over a pulse, START=100, WIDTH=10: posn_i steps 95->120 in one clk.
//     - err_o=1, act_o=0, pulse_o never rises.
//     - Re-arm clears err_o.
//  4. Abort and re-arm: enable_i drops at posn=105 inside a pulse.
//     - pulse_o=0 and act_o=0 next clk.
//     - Re-enable with posn=0: first pulse again at 100 (k reset).
//  5. Wrap: START=0x7FFFFFF0, STEP=0x10, WIDTH=4, NUM=2, posn_i ramps through 0x7FFFFFFF:
//     - second pulse at 0x80000000-0x80000003, no err_o.
//  6. Illegal config: STEP=0, then WIDTH=50 with STEP=50; enable_i rise in each case:
//     - err_o=1 next clk, act_o stays 0.
//     - Then assert reset_n_i=0 mid-pulse in test 1: all outputs 0 immediately.

Source files
------------

// File: rtl/panda_pcomp_pkg.sv
// Shared types and constants for the position-compare pulse generator.
package pcomp_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    WAIT_FALL = 2'd2
  } pcomp_state_t;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

endpackage

// File: rtl/panda_pcomp_cross.sv
// Wrap-safe "position has reached threshold" test in the direction of travel.
module pcomp_cross
  import pcomp_pkg::*;
#(
  parameter int PW = 32
) (
  input  logic [PW-1:0] posn,
  input  logic [PW-1:0] thr,
  input  logic          dir,
  output logic          crossed
);

  logic [PW-1:0] diff_s;

  // Sign of the modular difference decides; no magnitude compare so wrap is harmless
  always_comb begin
    diff_s = posn - thr;
    if (dir == DIR_NEG) begin
      crossed = diff_s[PW-1] | (diff_s == '0);
    end else begin
      crossed = ~diff_s[PW-1];
    end
  end

endmodule

// File: rtl/panda_pcomp.sv
// Position-compare pulse generator: NUM pulses of WIDTH, pitch STEP, from START,
// in positive or negative travel, with a sticky error for skipped pulses or bad config.
module panda_pcomp
  import pcomp_pkg::*;
#(
  parameter int PW = 32
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          enable_i,
  input  logic [PW-1:0] posn_i,
  input  logic [PW-1:0] START,
  input  logic [PW-1:0] STEP,
  input  logic [PW-1:0] WIDTH,
  input  logic [PW-1:0] NUM,
  input  logic          DIR,
  output logic          act_o,
  output logic          pulse_o,
  output logic          err_o
);

  localparam logic [PW-1:0] ONE = PW'(1);

  pcomp_state_t  state_r, state_s;
  logic          enable_d_r;
  logic [PW-1:0] step_r, width_r, num_r;
  logic          dir_r;
  logic [PW-1:0] rise_r, rise_s, k_r, k_s;
  logic          act_r, act_s, pulse_r, pulse_s, err_r, err_s;
  logic [PW-1:0] fall_s, rise_adv_s, k_inc_s;
  logic          arm_s, cfg_bad_s, cross_r_s, cross_f_s;

  // Point arithmetic and arm detection
  always_comb begin
    arm_s     = enable_i & ~enable_d_r;
    cfg_bad_s = (STEP == '0) | (WIDTH == '0) | (WIDTH >= STEP);
    k_inc_s   = k_r + ONE;
    if (dir_r == DIR_POS) begin
      fall_s     = rise_r + width_r;
      rise_adv_s = rise_r + step_r;
    end else begin
      fall_s     = rise_r - width_r;
      rise_adv_s = rise_r - step_r;
    end
  end

  pcomp_cross #(.PW(PW)) u_cross_rise (
    .posn    (posn_i),
    .thr     (rise_r),
    .dir     (dir_r),
    .crossed (cross_r_s)
  );

  pcomp_cross #(.PW(PW)) u_cross_fall (
    .posn    (posn_i),
    .thr     (fall_s),
    .dir     (dir_r),
    .crossed (cross_f_s)
  );

  // Next-state: abort beats arm, arm beats any compare hit
  always_comb begin
    state_s = state_r;
    act_s   = act_r;
    pulse_s = pulse_r;
    err_s   = err_r;
    k_s     = k_r;
    rise_s  = rise_r;
    if (!enable_i) begin
      state_s = IDLE;
      act_s   = 1'b0;
      pulse_s = 1'b0;
    end else if (arm_s) begin
      pulse_s = 1'b0;
      k_s     = '0;
      rise_s  = START;
      if (cfg_bad_s) begin
        err_s   = 1'b1;
        act_s   = 1'b0;
        state_s = IDLE;
      end else begin
        err_s   = 1'b0;
        act_s   = 1'b1;
        state_s = WAIT_RISE;
      end
    end else begin
      case (state_r)
        IDLE: begin
          act_s   = 1'b0;
          pulse_s = 1'b0;
        end
        WAIT_RISE: begin
          if (cross_f_s) begin
            err_s   = 1'b1;
            act_s   = 1'b0;
            state_s = IDLE;
          end else if (cross_r_s) begin
            pulse_s = 1'b1;
            state_s = WAIT_FALL;
          end else begin
            state_s = WAIT_RISE;
          end
        end
        WAIT_FALL: begin
          if (cross_f_s) begin
            pulse_s = 1'b0;
            k_s     = k_inc_s;
            rise_s  = rise_adv_s;
            if ((num_r != '0) && (k_inc_s == num_r)) begin
              act_s   = 1'b0;
              state_s = IDLE;
            end else begin
              state_s = WAIT_RISE;
            end
          end else begin
            state_s = WAIT_FALL;
          end
        end
        default: begin
          state_s = IDLE;
          act_s   = 1'b0;
          pulse_s = 1'b0;
        end
      endcase
    end
  end

  // Control and output registers; enable history resets high so an enable held
  // across reset is not mistaken for a fresh arm
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= IDLE;
      enable_d_r <= 1'b1;
      rise_r     <= '0;
      k_r        <= '0;
      act_r      <= 1'b0;
      pulse_r    <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      enable_d_r <= enable_i;
      rise_r     <= rise_s;
      k_r        <= k_s;
      act_r      <= act_s;
      pulse_r    <= pulse_s;
      err_r      <= err_s;
    end
  end

  // Configuration shadow, captured only when arming
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      step_r  <= '0;
      width_r <= '0;
      num_r   <= '0;
      dir_r   <= DIR_POS;
    end else if (arm_s) begin
      step_r  <= STEP;
      width_r <= WIDTH;
      num_r   <= NUM;
      dir_r   <= DIR;
    end else begin
      step_r  <= step_r;
      width_r <= width_r;
      num_r   <= num_r;
      dir_r   <= dir_r;
    end
  end

  assign act_o   = act_r;
  assign pulse_o = pulse_r;
  assign err_o   = err_r;

endmodule
